jk_bank_arbiter: RTL and testbench

- Shares a bank of WIDTH JK flip-flop cells between two requesters.
- Each requester issues one JK operation (hold/reset/set/toggle) on one bit index.
- Round-robin arbitration grants at most one operation per clock.
- The granted operation drives j/k of the selected cell only; all other cells see j=k=0 (hold).
- Sits between the sequencing logic of the lab datapath and the register bank, and replaces direct j/k wiring when more than one source must modify the bank.

---
 rtl/jk_pkg.sv | 12 +
 rtl/jk_cell.sv | 28 ++
 rtl/jk_bank_arbiter.sv | 81 ++++++++
 tb/tb_jk_bank_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared encodings for the JK register bank and its two-requester arbiter.
package jk_pkg;

   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_RST  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TGL  = 2'b11;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/jk_cell.sv
// One rising-edge JK flip-flop with synchronous clear; q1 is always the complement of q.
module jk_cell
   import jk_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic j,
   input  logic k,
   output logic q,
   output logic q1
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            JK_RST:  q <= 1'b0;
            JK_SET:  q <= 1'b1;
            JK_TGL:  q <= ~q;
            default: q <= q;
         endcase
      end
   end

   assign q1 = ~q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter letting two requesters apply one JK operation per clock to a shared bank of JK cells.
module jk_bank_arbiter
   import jk_pkg::*;
#(
   parameter int WIDTH = 6,
   parameter int IDXW  = 3
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req_valid,
   input  logic [1:0]       req0_op,
   input  logic [IDXW-1:0]  req0_idx,
   input  logic [1:0]       req1_op,
   input  logic [IDXW-1:0]  req1_idx,
   output logic [1:0]       req_ready,
   output logic [1:0]       done,
   output logic             err,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q1
);

   logic             last_grant;
   logic             gnt_id;
   logic             transfer;
   logic             idx_oob;
   logic [1:0]       sel_op;
   logic [IDXW-1:0]  sel_idx;
   logic [WIDTH-1:0] cell_j;
   logic [WIDTH-1:0] cell_k;

   // Under contention the requester that did not win last time gets the grant.
   always_comb begin
      req_ready = 2'b00;
      if (!reset) begin
         case (req_valid)
            2'b01:   req_ready = 2'b01;
            2'b10:   req_ready = 2'b10;
            2'b11:   req_ready = (last_grant == REQ1) ? 2'b01 : 2'b10;
            default: req_ready = 2'b00;
         endcase
      end
   end

   assign transfer = |req_ready;
   assign gnt_id   = req_ready[1] ? REQ1 : REQ0;
   assign sel_op   = (gnt_id == REQ1) ? req1_op  : req0_op;
   assign sel_idx  = (gnt_id == REQ1) ? req1_idx : req0_idx;
   assign idx_oob  = int'(sel_idx) >= WIDTH;

   for (genvar c = 0; c < WIDTH; c++) begin : g_cell
      logic hit;
      assign hit       = transfer && (sel_idx == IDXW'(c));
      assign cell_j[c] = hit & sel_op[1];
      assign cell_k[c] = hit & sel_op[0];

      jk_cell u_cell (
         .clk   (clk),
         .reset (reset),
         .j     (cell_j[c]),
         .k     (cell_k[c]),
         .q     (q[c]),
         .q1    (q1[c])
      );
   end

   // Every accepted op, including holds and out-of-range targets, moves the round-robin pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= REQ1;
         done       <= 2'b00;
         err        <= 1'b0;
      end else begin
         done <= req_ready;
         err  <= transfer && idx_oob;
         if (transfer) begin
            last_grant <= gnt_id;
         end
      end
   end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed-vector bench for jk_bank_arbiter with hand-computed expectations.
module tb_jk_bank_arbiter;
   import jk_pkg::*;

   localparam int WIDTH = 6;
   localparam int IDXW  = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic [1:0]       req_valid;
   logic [1:0]       req0_op;
   logic [IDXW-1:0]  req0_idx;
   logic [1:0]       req1_op;
   logic [IDXW-1:0]  req1_idx;
   logic [1:0]       req_ready;
   logic [1:0]       done;
   logic             err;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q1;

   int checks = 0;
   int errors = 0;

   logic [1:0]      pending = 2'b00;
   logic [1:0]      prev_op [2];
   logic [IDXW-1:0] prev_idx[2];

   jk_bank_arbiter #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req0_op   (req0_op),
      .req0_idx  (req0_idx),
      .req1_op   (req1_op),
      .req1_idx  (req1_idx),
      .req_ready (req_ready),
      .done      (done),
      .err       (err),
      .q         (q),
      .q1        (q1)
   );

   always #5 clk = ~clk;

   // Apply one cycle of inputs on the falling edge; an ungranted requester must keep its request stable.
   task automatic drive(input logic rst, input logic [1:0] v,
                        input logic [1:0] op0, input logic [IDXW-1:0] i0,
                        input logic [1:0] op1, input logic [IDXW-1:0] i1);
      @(negedge clk);
      if (!rst) begin
         for (int r = 0; r < 2; r++) begin
            if (pending[r]) begin
               checks++;
               if (!v[r] || (r == 0 ? op0 : op1) !== prev_op[r] || (r == 0 ? i0 : i1) !== prev_idx[r]) begin
                  errors++;
                  $display("[TB] FAIL handshake_hold req%0d: valid=%b op/idx changed while waiting (required stable %b/%0d)",
                           r, v[r], prev_op[r], prev_idx[r]);
               end
            end
         end
      end
      reset     = rst;
      req_valid = v;
      req0_op   = op0;
      req0_idx  = i0;
      req1_op   = op1;
      req1_idx  = i1;
      #1;
      pending     = rst ? 2'b00 : (v & ~req_ready);
      prev_op[0]  = op0;
      prev_op[1]  = op1;
      prev_idx[0] = i0;
      prev_idx[1] = i1;
   endtask

   task automatic commit;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      drive(1'b1, 2'b00, JK_HOLD, 0, JK_HOLD, 0);
      commit();
      drive(1'b1, 2'b00, JK_HOLD, 0, JK_HOLD, 0);
      commit();
      for (int c = 0; c < 3; c++) begin
         drive(1'b0, 2'b00, JK_HOLD, 0, JK_HOLD, 0);
         checks++;
         if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready: got %b need 00", req_ready); end
         commit();
      end
      checks++;
      if (q !== 6'b000000) begin errors++; $display("[TB] FAIL reset_q: got %b need 000000", q); end
      checks++;
      if (q1 !== 6'b111111) begin errors++; $display("[TB] FAIL reset_q1: got %b need 111111", q1); end
      checks++;
      if (done !== 2'b00 || err !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_done_err: got done=%b err=%b need 00/0", done, err);
      end
   endtask

   task automatic test_set_toggle;
      drive(1'b0, 2'b01, JK_SET, 2, JK_HOLD, 0);
      checks++;
      if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL st_ready0: got %b need 01", req_ready); end
      commit();
      checks++;
      if (q !== 6'b000100 || done !== 2'b01) begin
         errors++; $display("[TB] FAIL st_set: got q=%b done=%b need 000100/01", q, done);
      end
      drive(1'b0, 2'b10, JK_HOLD, 0, JK_TGL, 2);
      checks++;
      if (req_ready !== 2'b10) begin errors++; $display("[TB] FAIL st_ready1: got %b need 10", req_ready); end
      commit();
      checks++;
      if (q !== 6'b000000 || q1 !== 6'b111111 || done !== 2'b10) begin
         errors++; $display("[TB] FAIL st_toggle: got q=%b q1=%b done=%b need 000000/111111/10", q, q1, done);
      end
   endtask

   task automatic test_alternate;
      logic [1:0]       exp_rdy[5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
      logic [WIDTH-1:0] exp_q  [5] = '{6'b000001, 6'b100001, 6'b100001, 6'b100001, 6'b100001};
      for (int c = 0; c < 5; c++) begin
         drive(1'b0, (c == 4) ? 2'b01 : 2'b11, JK_SET, 0, JK_SET, 5);
         checks++;
         if (req_ready !== exp_rdy[c]) begin
            errors++; $display("[TB] FAIL alt_ready[%0d]: got %b need %b", c, req_ready, exp_rdy[c]);
         end
         commit();
         checks++;
         if (q !== exp_q[c] || done !== exp_rdy[c] || q1 !== ~exp_q[c]) begin
            errors++; $display("[TB] FAIL alt_commit[%0d]: got q=%b q1=%b done=%b need %b/%b/%b",
                               c, q, q1, done, exp_q[c], ~exp_q[c], exp_rdy[c]);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [WIDTH-1:0] exp_q[3] = '{6'b101001, 6'b100001, 6'b101001};
      for (int c = 0; c < 3; c++) begin
         drive(1'b0, 2'b10, JK_HOLD, 0, JK_TGL, 3);
         checks++;
         if (req_ready !== 2'b10) begin errors++; $display("[TB] FAIL b2b_ready[%0d]: got %b need 10", c, req_ready); end
         commit();
         checks++;
         if (q !== exp_q[c] || q1 !== ~exp_q[c] || done !== 2'b10) begin
            errors++; $display("[TB] FAIL b2b_q[%0d]: got q=%b done=%b need %b/10", c, q, done, exp_q[c]);
         end
      end
   endtask

   task automatic test_out_of_range;
      drive(1'b0, 2'b01, JK_SET, 7, JK_HOLD, 0);
      checks++;
      if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL oob_ready: got %b need 01", req_ready); end
      commit();
      checks++;
      if (q !== 6'b101001 || done !== 2'b01 || err !== 1'b1) begin
         errors++; $display("[TB] FAIL oob_commit: got q=%b done=%b err=%b need 101001/01/1", q, done, err);
      end
      drive(1'b0, 2'b00, JK_HOLD, 0, JK_HOLD, 0);
      commit();
      checks++;
      if (done !== 2'b00 || err !== 1'b0) begin
         errors++; $display("[TB] FAIL oob_pulse: got done=%b err=%b need 00/0", done, err);
      end
   endtask

   task automatic test_hold;
      drive(1'b0, 2'b01, JK_HOLD, 1, JK_HOLD, 0);
      commit();
      checks++;
      if (q !== 6'b101001 || done !== 2'b01 || err !== 1'b0) begin
         errors++; $display("[TB] FAIL hold_commit: got q=%b done=%b err=%b need 101001/01/0", q, done, err);
      end
   endtask

   task automatic test_reset_override;
      for (int b = 0; b < WIDTH; b++) begin
         drive(1'b0, 2'b01, JK_SET, IDXW'(b), JK_HOLD, 0);
         commit();
      end
      checks++;
      if (q !== 6'b111111) begin errors++; $display("[TB] FAIL ovr_fill: got %b need 111111", q); end
      drive(1'b1, 2'b01, JK_RST, 0, JK_HOLD, 0);
      checks++;
      if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL ovr_ready: got %b need 00", req_ready); end
      commit();
      checks++;
      if (q !== 6'b000000 || q1 !== 6'b111111 || done !== 2'b00 || err !== 1'b0) begin
         errors++; $display("[TB] FAIL ovr_state: got q=%b q1=%b done=%b err=%b need 000000/111111/00/0", q, q1, done, err);
      end
      drive(1'b0, 2'b11, JK_SET, 1, JK_SET, 4);
      checks++;
      if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL ovr_first_grant: got %b need 01", req_ready); end
      commit();
      checks++;
      if (q !== 6'b000010 || done !== 2'b01) begin
         errors++; $display("[TB] FAIL ovr_commit0: got q=%b done=%b need 000010/01", q, done);
      end
      drive(1'b0, 2'b10, JK_HOLD, 0, JK_SET, 4);
      commit();
      checks++;
      if (q !== 6'b010010 || done !== 2'b10) begin
         errors++; $display("[TB] FAIL ovr_commit1: got q=%b done=%b need 010010/10", q, done);
      end
      drive(1'b0, 2'b00, JK_HOLD, 0, JK_HOLD, 0);
      commit();
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 2'b00;
      req0_op   = JK_HOLD;
      req0_idx  = '0;
      req1_op   = JK_HOLD;
      req1_idx  = '0;
      test_reset();
      test_set_toggle();
      test_alternate();
      test_back_to_back();
      test_out_of_range();
      test_hold();
      test_reset_override();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
